// File: rtl/ram_access_sequencer.sv
// Arbitrates two requesters onto the RAM write port and read port 1,
// sequencing direct and pointer-indirect loads and stores.
module ram_access_sequencer #(
    parameter int DATA_W = 11,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic [1:0]        a_op,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic [1:0]        b_op,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              busy,
    output logic              grant
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PTR    = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic              win_b;
    logic [ADDR_W-1:0] eff;

    // On a tie the requester that was not served last wins.
    assign win_b = b_req & (~a_req | ~last_grant_q);
    assign eff   = op_q[1] ? ptr_q : addr_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ptr_d        = ptr_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (a_req | b_req) begin
                    grant_d      = win_b;
                    last_grant_d = win_b;
                    op_d         = win_b ? b_op    : a_op;
                    addr_d       = win_b ? b_addr  : a_addr;
                    wdata_d      = win_b ? b_wdata : a_wdata;
                    state_d      = op_d[1] ? S_PTR : S_ACCESS;
                end
            end
            S_PTR: begin
                ptr_d   = ram_rd_data[ADDR_W-1:0];
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (op_q[0]) begin
                    if (grant_q) b_rdata_d = ram_rd_data;
                    else         a_rdata_d = ram_rd_data;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ptr_q        <= '0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ptr_q        <= ptr_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    // RAM controls decode from registered state so reset kills a write at once.
    always_comb begin
        ram_wr_en   = (state_q == S_ACCESS) & ~op_q[0];
        ram_wr_addr = ram_wr_en ? eff : '0;
        ram_wr_data = ram_wr_en ? wdata_q : '0;
        ram_rd_addr = '0;
        if (state_q == S_PTR)
            ram_rd_addr = addr_q;
        else if ((state_q == S_ACCESS) && op_q[0])
            ram_rd_addr = eff;
    end

    assign a_ack   = (state_q == S_DONE) & ~grant_q;
    assign b_ack   = (state_q == S_DONE) & grant_q;
    assign busy    = (state_q != S_IDLE);
    assign grant   = grant_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule
